// File: rtl/stack_frame_sequencer.sv
// Stack frame sequencer: performs the memory pushes/pops for CALL, RET, INT
// and RTI, then commits the final SP (and PC/FLAGS where applicable) in a
// single COMMIT cycle. Shares the data-memory port through mem_grant.
module stack_frame_sequencer #(
  parameter int              DW         = 8,
  parameter int              FW         = 4,
  parameter logic [DW-1:0]   INT_VECTOR = 8'h01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [1:0]    req_op,
  output logic          req_ready,
  input  logic [DW-1:0] sp_in,
  input  logic          sp_not_ready,
  input  logic [DW-1:0] ret_pc,
  input  logic [FW-1:0] flags_in,
  input  logic          mem_grant,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          sp_we,
  output logic [DW-1:0] sp_wdata,
  output logic          pc_load,
  output logic [DW-1:0] pc_value,
  output logic          flags_load,
  output logic [FW-1:0] flags_value,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    OP_CALL = 2'b00,
    OP_RET  = 2'b01,
    OP_INT  = 2'b10,
    OP_RTI  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_PC  = 3'd1,
    S_PUSH_FL  = 3'd2,
    S_POP_REQ  = 3'd3,
    S_POP_WAIT = 3'd4,
    S_COMMIT   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] sp_q, sp_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [FW-1:0] flags_q, flags_d;
  // Set once the flags word of an RTI has been popped; the next pop is the PC.
  logic          second_q, second_d;
  // Last committed values, held on the outputs outside COMMIT.
  logic [DW-1:0] sp_wdata_q, sp_wdata_d;
  logic [DW-1:0] pc_value_q, pc_value_d;
  logic [FW-1:0] flags_value_q, flags_value_d;

  // State and operand registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_CALL;
      sp_q          <= '0;
      pc_q          <= '0;
      flags_q       <= '0;
      second_q      <= 1'b0;
      sp_wdata_q    <= '0;
      pc_value_q    <= '0;
      flags_value_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      sp_q          <= sp_d;
      pc_q          <= pc_d;
      flags_q       <= flags_d;
      second_q      <= second_d;
      sp_wdata_q    <= sp_wdata_d;
      pc_value_q    <= pc_value_d;
      flags_value_q <= flags_value_d;
    end
  end

  // Next-state sequencing, memory strobes and commit outputs.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    sp_d          = sp_q;
    pc_d          = pc_q;
    flags_d       = flags_q;
    second_d      = second_q;
    sp_wdata_d    = sp_wdata_q;
    pc_value_d    = pc_value_q;
    flags_value_d = flags_value_q;

    req_ready   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    sp_we       = 1'b0;
    pc_load     = 1'b0;
    flags_load  = 1'b0;
    done        = 1'b0;
    sp_wdata    = sp_wdata_q;
    pc_value    = pc_value_q;
    flags_value = flags_value_q;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        req_ready = ~sp_not_ready & ~rst;
        if (req_valid && req_ready) begin
          op_d     = op_e'(req_op);
          sp_d     = sp_in;
          pc_d     = ret_pc;
          flags_d  = flags_in;
          second_d = 1'b0;
          if ((op_e'(req_op) == OP_CALL) || (op_e'(req_op) == OP_INT)) begin
            state_d = S_PUSH_PC;
          end else begin
            state_d = S_POP_REQ;
          end
        end
      end

      S_PUSH_PC: begin
        // Address/data are driven while waiting so they stay stable under stall.
        mem_addr  = sp_q;
        mem_wdata = pc_q;
        if (mem_grant) begin
          mem_we  = 1'b1;
          sp_d    = sp_q - DW'(1);
          state_d = (op_q == OP_INT) ? S_PUSH_FL : S_COMMIT;
        end
      end

      S_PUSH_FL: begin
        mem_addr  = sp_q;
        mem_wdata = {{(DW-FW){1'b0}}, flags_q};
        if (mem_grant) begin
          mem_we  = 1'b1;
          sp_d    = sp_q - DW'(1);
          state_d = S_COMMIT;
        end
      end

      S_POP_REQ: begin
        // Pop pre-increments: the word lives one above the current SP.
        mem_addr = sp_q + DW'(1);
        if (mem_grant) begin
          mem_re  = 1'b1;
          sp_d    = sp_q + DW'(1);
          state_d = S_POP_WAIT;
        end
      end

      S_POP_WAIT: begin
        // RTI pops FLAGS first (pushed last by INT), then the return PC.
        if ((op_q == OP_RTI) && !second_q) begin
          flags_d  = mem_rdata[FW-1:0];
          second_d = 1'b1;
          state_d  = S_POP_REQ;
        end else begin
          pc_d    = mem_rdata;
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        sp_we      = 1'b1;
        done       = 1'b1;
        sp_wdata   = sp_q;
        sp_wdata_d = sp_q;
        case (op_q)
          OP_RET, OP_RTI: begin
            pc_load    = 1'b1;
            pc_value   = pc_q;
            pc_value_d = pc_q;
          end
          OP_INT: begin
            pc_load    = 1'b1;
            pc_value   = INT_VECTOR;
            pc_value_d = INT_VECTOR;
          end
          default: begin
            // CALL target comes from the pipeline; PC is left alone.
          end
        endcase
        if (op_q == OP_RTI) begin
          flags_load    = 1'b1;
          flags_value   = flags_q;
          flags_value_d = flags_q;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reset cycle drops any memory access and suppresses any commit.
    if (rst) begin
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      sp_we      = 1'b0;
      pc_load    = 1'b0;
      flags_load = 1'b0;
      done       = 1'b0;
    end
  end

endmodule
